// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory unit between the CPU memory stage and a DMA master.
// Each access is serialized as grant -> start pulse -> wait for done (or watchdog abort) -> ack.
module mem_arbiter #(
    parameter int ADDR_W      = 27,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic [DATA_W-1:0] cpu_q,
    output logic              cpu_ack,
    output logic              cpu_err,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_data,
    output logic [DATA_W-1:0] dma_q,
    output logic              dma_ack,
    output logic              dma_err,

    output logic              mem_start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_q,
    input  logic              mem_done,

    output logic              owner
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]      state;
    logic            last_grant;
    logic [WD_W-1:0] wd;
    logic [WD_W-1:0] wd_inc;
    logic            wd_limit;
    logic            any_req;
    logic            grant_dma;
    logic            finish;

    always_comb begin
        any_req   = cpu_req | dma_req;
        // On a tie the port that did not win last time is served.
        grant_dma = dma_req & (~cpu_req | ~last_grant);
        wd_inc    = wd + 1'b1;
        wd_limit  = (wd_inc == WD_W'(TIMEOUT_CYC));
        finish    = (state == WAIT) & (mem_done | wd_limit);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wd         <= '0;
            owner      <= 1'b0;
            mem_start  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
        end else begin
            mem_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        mem_we     <= grant_dma ? dma_we   : cpu_we;
                        mem_addr   <= grant_dma ? dma_addr : cpu_addr;
                        mem_data   <= grant_dma ? dma_data : cpu_data;
                        owner      <= grant_dma;
                        last_grant <= grant_dma;
                        wd         <= '0;
                        mem_start  <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    wd <= wd_inc;
                    if (finish) state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Responses land in the owner's registers; the other port keeps its last result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_q   <= '0;
            cpu_err <= 1'b0;
            cpu_ack <= 1'b0;
            dma_q   <= '0;
            dma_err <= 1'b0;
            dma_ack <= 1'b0;
        end else begin
            cpu_ack <= finish & ~owner;
            dma_ack <= finish & owner;
            if (finish && !owner) begin
                cpu_q   <= mem_done ? mem_q : '0;
                cpu_err <= ~mem_done;
            end
            if (finish && owner) begin
                dma_q   <= mem_done ? mem_q : '0;
                dma_err <= ~mem_done;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-timeline model checked every cycle, plus directed
// scenarios with hand-computed latencies and data.
module tb_mem_arbiter;

    localparam int AW = 27;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_data = '0;
    logic [DW-1:0] cpu_q;
    logic          cpu_ack, cpu_err;
    logic          dma_req = 1'b0, dma_we = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [DW-1:0] dma_data = '0;
    logic [DW-1:0] dma_q;
    logic          dma_ack, dma_err;
    logic          mem_start, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_q = '0;
    logic          mem_done = 1'b0;
    logic          owner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_q(cpu_q), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_data(dma_data),
        .dma_q(dma_q), .dma_ack(dma_ack), .dma_err(dma_err),
        .mem_start(mem_start), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_q(mem_q), .mem_done(mem_done), .owner(owner)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: an access is a timeline counted from its grant cycle (t=0). Start is at t=1,
    // done is accepted from t=2, and the watchdog fires after TO waiting cycles.
    bit            m_busy = 0, m_resp = 0, m_who = 0, m_last = 1;
    int            m_t = 0;
    logic          m_we = 0, m_owner = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic [DW-1:0] m_q [2] = '{default: '0};
    bit            m_err [2] = '{default: 0};
    bit            m_ack [2] = '{default: 0};

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_resp = 0; m_last = 1; m_t = 0;
            m_we = 0; m_owner = 0; m_addr = '0; m_data = '0;
            for (int i = 0; i < 2; i++) begin m_q[i] = '0; m_err[i] = 0; m_ack[i] = 0; end
        end else begin
            m_ack[0] = 0;
            m_ack[1] = 0;
            if (!m_busy) begin
                if (cpu_req || dma_req) begin
                    m_who   = (cpu_req && dma_req) ? !m_last : dma_req;
                    m_last  = m_who;
                    m_owner = m_who;
                    m_we    = m_who ? dma_we   : cpu_we;
                    m_addr  = m_who ? dma_addr : cpu_addr;
                    m_data  = m_who ? dma_data : cpu_data;
                    m_busy  = 1;
                    m_t     = 1;
                end
            end else if (m_resp) begin
                m_busy = 0;
                m_resp = 0;
            end else begin
                if (m_t >= 2 && (mem_done || (m_t - 1) == TO)) begin
                    m_q[m_who]   = mem_done ? mem_q : '0;
                    m_err[m_who] = !mem_done;
                    m_ack[m_who] = 1;
                    m_resp       = 1;
                end
                m_t++;
            end
        end
    end

    always @(negedge clk) begin
        chk("mem_start", mem_start, m_busy && !m_resp && m_t == 1);
        chk("mem_we",    mem_we,    m_we);
        chk("mem_addr",  mem_addr,  m_addr);
        chk("mem_data",  mem_data,  m_data);
        chk("owner",     owner,     m_owner);
        chk("cpu_ack",   cpu_ack,   m_ack[0]);
        chk("dma_ack",   dma_ack,   m_ack[1]);
        chk("cpu_err",   cpu_err,   m_err[0]);
        chk("dma_err",   dma_err,   m_err[1]);
        chk("cpu_q",     cpu_q,     m_q[0]);
        chk("dma_q",     dma_q,     m_q[1]);
    end

    // Memory unit stand-in: done 'lat' cycles after start (0 = never), plus one-shot strays.
    int            lat = 1;
    int            cnt = 0;
    bit            stray = 0;
    logic [DW-1:0] rq = '0;

    always @(posedge clk) begin
        #2;
        mem_done = 1'b0;
        if (!reset) begin
            cnt = 0;
        end else begin
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin mem_done = 1'b1; mem_q = rq; end
            end
            if (stray) begin mem_done = 1'b1; mem_q = 32'hBAD0_BAD0; stray = 0; end
            if (mem_start && lat > 0) cnt = lat;
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Returns the number of cycles from the current cycle to the ack cycle.
    task automatic wait_ack(input bit port, input int maxc, output int n);
        bit seen = 0;
        n = 0;
        while (!seen && n <= maxc) begin
            @(negedge clk);
            if ((port ? dma_ack : cpu_ack) === 1'b1) seen = 1;
            else n++;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL ack_timeout port %0d waited %0d cycles", port, n);
        end
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "bench timeout");
    end

    initial begin
        int n, k, acks, starts;
        logic [AW-1:0] ga [4];
        logic          go [4];
        logic [DW-1:0] qs;

        step(2);
        chk("rst_owner", owner, 1'b0);
        chk("rst_start", mem_start, 1'b0);
        reset = 1'b1;
        step(1);

        // Single CPU read, done 2 cycles after start.
        lat = 2; rq = 32'hDEAD_BEEF;
        cpu_addr = 27'h40; cpu_we = 1'b0; cpu_req = 1'b1;
        acks = 0;
        fork
            begin wait_ack(0, 20, n); end
            begin repeat (6) begin @(negedge clk); if (dma_ack) acks++; end end
        join
        chk("t1_latency", n, 4);
        chk("t1_q", cpu_q, 32'hDEAD_BEEF);
        chk("t1_err", cpu_err, 1'b0);
        chk("t1_no_dma_ack", acks, 0);
        step(1); cpu_req = 1'b0;
        step(3);

        // Both ports requesting continuously from reset.
        reset = 1'b0;
        lat = 1; rq = 32'h1111_2222;
        cpu_addr = 27'h10; dma_addr = 27'h20; cpu_req = 1'b1; dma_req = 1'b1;
        step(2);
        reset = 1'b1;
        k = 0;
        for (int c = 0; c < 60 && k < 4; c++) begin
            @(negedge clk);
            if (mem_start) begin ga[k] = mem_addr; go[k] = owner; k++; end
        end
        chk("t2_starts", k, 4);
        chk("t2_a0", ga[0], 27'h10); chk("t2_o0", go[0], 1'b0);
        chk("t2_a1", ga[1], 27'h20); chk("t2_o1", go[1], 1'b1);
        chk("t2_a2", ga[2], 27'h10); chk("t2_o2", go[2], 1'b0);
        chk("t2_a3", ga[3], 27'h20); chk("t2_o3", go[3], 1'b1);
        step(1); cpu_req = 1'b0; dma_req = 1'b0;
        step(10);

        // DMA write that never completes: watchdog abort, then a normal access.
        lat = 0;
        dma_we = 1'b1; dma_addr = 27'h123; dma_data = 32'h55; dma_req = 1'b1;
        wait_ack(1, 40, n);
        chk("t3_latency", n, TO + 2);
        chk("t3_err", dma_err, 1'b1);
        chk("t3_q", dma_q, 32'h0);
        step(1); dma_req = 1'b0;
        step(2);
        lat = 1; rq = 32'h1234_5678;
        dma_we = 1'b0; dma_addr = 27'h124; dma_req = 1'b1;
        wait_ack(1, 20, n);
        chk("t3b_latency", n, 3);
        chk("t3b_err", dma_err, 1'b0);
        chk("t3b_q", dma_q, 32'h1234_5678);
        step(1); dma_req = 1'b0;
        step(2);

        // Done arrives on the same cycle the watchdog expires: done wins.
        lat = TO; rq = 32'hCAFE_F00D;
        cpu_we = 1'b0; cpu_addr = 27'h55; cpu_req = 1'b1;
        wait_ack(0, 40, n);
        chk("t4_latency", n, TO + 2);
        chk("t4_err", cpu_err, 1'b0);
        chk("t4_q", cpu_q, 32'hCAFE_F00D);
        step(1); cpu_req = 1'b0;
        step(2);

        // Reset in the middle of a DMA wait.
        lat = 0;
        dma_we = 1'b1; dma_addr = 27'h77; dma_data = 32'h99; dma_req = 1'b1;
        step(4);
        #2 reset = 1'b0;
        #1;
        chk("t5_start", mem_start, 1'b0);
        chk("t5_we", mem_we, 1'b0);
        chk("t5_addr", mem_addr, 27'h0);
        chk("t5_data", mem_data, 32'h0);
        chk("t5_owner", owner, 1'b0);
        chk("t5_cpu_q", cpu_q, 32'h0);
        chk("t5_dma_q", dma_q, 32'h0);
        chk("t5_acks", {cpu_ack, dma_ack, cpu_err, dma_err}, 4'h0);
        dma_req = 1'b0;
        step(2);
        reset = 1'b1;
        acks = 0;
        repeat (20) begin @(negedge clk); if (cpu_ack || dma_ack) acks++; end
        chk("t5_no_ack", acks, 0);
        step(1);
        lat = 1; rq = 32'h0F0F_0F0F;
        cpu_we = 1'b0; cpu_addr = 27'h31; dma_we = 1'b0; dma_addr = 27'h32;
        cpu_req = 1'b1; dma_req = 1'b1;
        starts = 0;
        for (int c = 0; c < 10 && starts == 0; c++) begin
            @(negedge clk);
            if (mem_start) begin
                starts++;
                chk("t5_tie_owner", owner, 1'b0);
                chk("t5_tie_addr", mem_addr, 27'h31);
            end
        end
        chk("t5_tie_started", starts, 1);
        wait_ack(0, 20, n);
        step(1); cpu_req = 1'b0; dma_req = 1'b0;
        step(4);

        // CPU withdraws req after the grant; stray done pulses in ISSUE and IDLE.
        lat = 3; rq = 32'hA5A5_A5A5;
        cpu_addr = 27'h66; cpu_req = 1'b1;
        step(1);
        stray = 1;
        step(1);
        cpu_req = 1'b0;
        acks = 0; qs = '0;
        repeat (12) begin
            @(negedge clk);
            if (cpu_ack) begin acks++; qs = cpu_q; end
        end
        chk("t6_one_ack", acks, 1);
        chk("t6_q", qs, 32'hA5A5_A5A5);
        acks = 0; starts = 0;
        for (int i = 0; i < 3; i++) begin
            stray = 1;
            repeat (3) begin
                @(negedge clk);
                if (cpu_ack || dma_ack) acks++;
                if (mem_start) starts++;
            end
            step(1);
        end
        chk("t6_stray_acks", acks, 0);
        chk("t6_stray_starts", starts, 0);
        chk("t6_q_held", cpu_q, 32'hA5A5_A5A5);

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
